// File: rtl/note_phase_pkg.sv
// note_phase_pkg
// Shared types and constants for the per-voice phase controller.
//   phase_t        : 32-bit unsigned phase / increment word (wraps mod 2^32)
//   phase_state_t  : voice FSM states; RELEASE exists only when
//                    ZERO_CROSS_RELEASE_EN is defined
//   BASE_INC       : octave-4 increments, round(f * 2^32 / 8000), C..B
//   oct_shift()    : moves an octave-4 increment to any octave 0..7
package note_phase_pkg;

    typedef logic [31:0] phase_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1
`ifdef ZERO_CROSS_RELEASE_EN
        ,
        RELEASE = 2'd2
`endif
    } phase_state_t;

    // Octave-4 phase increments at an 8 kHz sample rate.
    localparam phase_t BASE_INC [12] = '{
        32'd140459174,  // C4
        32'd148811275,  // C#4
        32'd157660089,  // D4
        32'd167035036,  // D#4
        32'd176967470,  // E4
        32'd187490462,  // F4
        32'd198639231,  // F#4
        32'd210450928,  // G4
        32'd222965013,  // G#4
        32'd236223201,  // A4
        32'd250269784,  // A#4
        32'd265151578   // B4
    };

    // Each octave doubles the frequency; below octave 4 the shift is a
    // logical right shift, so low octaves truncate toward zero.
    function automatic phase_t oct_shift(input phase_t inc, input logic [2:0] octave);
        if (octave >= 3'd4) begin
            return inc << (octave - 3'd4);
        end
        return inc >> (3'd4 - octave);
    endfunction

endpackage

// File: rtl/note_phase_controller_sample_tick_gen.sv
// sample_tick_gen
// Free-running divider producing a one-cycle tick every DIV clocks.
//   clk_in   : clock
//   rst_in   : synchronous, active-low reset (count returns to 0)
//   tick_out : high on the cycle where the count equals DIV-1
// The first tick appears DIV-1 cycles after reset is released.
module sample_tick_gen #(
    parameter int unsigned DIV = 12500
) (
    input  logic clk_in,
    input  logic rst_in,
    output logic tick_out
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_out = (count_q == LAST);

endmodule

// File: rtl/note_phase_controller.sv
// note_phase_controller
// Per-voice phase controller feeding a combinational sine generator.
// Turns note-on/note-off commands into a phase increment, produces the
// sample strobe and holds the voice phase, closing the loop through the
// sine generator's full_phase_next_out.
//
// Ports
//   clk_in              : clock
//   rst_in              : synchronous, active-low reset
//   cmd_valid_in        : one-cycle command strobe
//   cmd_on_in           : 1 = note-on, 0 = note-off
//   note_in             : semitone 0..11 (C..B); >= 12 rejects a note-on
//   octave_in           : octave 0..7
//   full_phase_next_in  : phase + increment from the sine generator
//   sample_step_out     : one-cycle strobe every CLK_HZ/SAMPLE_HZ cycles
//   phase_out           : to the sine generator's phase_offset_in
//   phase_increment_out : to the sine generator's phase_increment
//   playing_out         : to the sine generator's valid_info_in
//   cmd_error_out       : one-cycle pulse after a rejected note-on
//
// Build option: ZERO_CROSS_RELEASE_EN
//   defined   : note-off enters RELEASE and the voice stops at the next
//               phase wrap, avoiding a click
//   undefined : note-off stops the voice on the consuming strobe
module note_phase_controller
    import note_phase_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned SAMPLE_HZ = 8000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cmd_valid_in,
    input  logic        cmd_on_in,
    input  logic [3:0]  note_in,
    input  logic [2:0]  octave_in,
    input  logic [31:0] full_phase_next_in,
    output logic        sample_step_out,
    output logic [31:0] phase_out,
    output logic [31:0] phase_increment_out,
    output logic        playing_out,
    output logic        cmd_error_out
);

    localparam int unsigned DIV = CLK_HZ / SAMPLE_HZ;

    logic strobe;

    sample_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .tick_out (strobe)
    );

    assign sample_step_out = strobe;

    // ---------------------------------------------------------------
    // Command decode: the increment is computed at capture time so the
    // pending slot only has to hold the final word.
    // ---------------------------------------------------------------
    logic       cmd_bad;
    logic       cmd_take;
    logic [3:0] note_idx;
    phase_t     cmd_inc;

    always_comb begin
        cmd_bad  = cmd_valid_in & cmd_on_in & (note_in >= 4'd12);
        cmd_take = cmd_valid_in & ~cmd_bad;
        // Clamp the table index so an out-of-range note never reads past the table.
        note_idx = (note_in >= 4'd12) ? 4'd0 : note_in;
        cmd_inc  = cmd_on_in ? oct_shift(BASE_INC[note_idx], octave_in) : '0;
    end

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    phase_state_t state_q, state_d;
    phase_t       phase_q, phase_d;
    phase_t       inc_q, inc_d;
    logic         playing_q, playing_d;
    logic         cmd_error_q, cmd_error_d;
    logic         pend_valid_q, pend_valid_d;
    logic         pend_on_q, pend_on_d;
    phase_t       pend_inc_q, pend_inc_d;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        inc_d        = inc_q;
        pend_valid_d = pend_valid_q;
        pend_on_d    = pend_on_q;
        pend_inc_d   = pend_inc_q;
        cmd_error_d  = cmd_bad;

        if (strobe) begin
            // The strobe always consumes whatever the slot held before this cycle.
            pend_valid_d = 1'b0;
            case (state_q)
                IDLE: begin
                    // Phase is already 0 here, so a new note starts from 0.
                    if (pend_valid_q && pend_on_q) begin
                        state_d = PLAY;
                        inc_d   = pend_inc_q;
                    end
                end
                PLAY: begin
                    phase_d = full_phase_next_in;
                    if (pend_valid_q) begin
                        if (pend_on_q) begin
                            // Legato retune: increment changes, phase keeps running.
                            inc_d = pend_inc_q;
                        end else begin
`ifdef ZERO_CROSS_RELEASE_EN
                            state_d = RELEASE;
`else
                            state_d = IDLE;
                            phase_d = '0;
                            inc_d   = '0;
`endif
                        end
                    end
                end
`ifdef ZERO_CROSS_RELEASE_EN
                RELEASE: begin
                    phase_d = full_phase_next_in;
                    // A fresh note-on wins over a coincident wrap.
                    if (pend_valid_q && pend_on_q) begin
                        state_d = PLAY;
                        inc_d   = pend_inc_q;
                    end else if (full_phase_next_in < phase_q) begin
                        // Unsigned wrap: the waveform is back at its start point.
                        state_d = IDLE;
                        phase_d = '0;
                        inc_d   = '0;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    phase_d = '0;
                    inc_d   = '0;
                end
            endcase
        end

        // A command landing on a strobe cycle refills the slot for the next strobe.
        if (cmd_take) begin
            pend_valid_d = 1'b1;
            pend_on_d    = cmd_on_in;
            pend_inc_d   = cmd_inc;
        end

        playing_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            inc_q        <= '0;
            playing_q    <= 1'b0;
            cmd_error_q  <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_on_q    <= 1'b0;
            pend_inc_q   <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            inc_q        <= inc_d;
            playing_q    <= playing_d;
            cmd_error_q  <= cmd_error_d;
            pend_valid_q <= pend_valid_d;
            pend_on_q    <= pend_on_d;
            pend_inc_q   <= pend_inc_d;
        end
    end

    assign phase_out           = phase_q;
    assign phase_increment_out = inc_q;
    assign playing_out         = playing_q;
    assign cmd_error_out       = cmd_error_q;

endmodule

// File: tb/tb_note_phase_controller.sv
// Bench for note_phase_controller with a shrunken divider (N = 16).
// The sine generator is modelled as phase + increment. A cycle-level
// reference model built from the note rules (frequency table, octave
// doubling, strobe counting) runs alongside the DUT.
module tb_note_phase_controller;

    localparam int unsigned N = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_on;
    logic [3:0]  note;
    logic [2:0]  octave;
    logic [31:0] fpn;
    logic        step;
    logic [31:0] phase;
    logic [31:0] inc;
    logic        playing;
    logic        err;

    always #5 clk = ~clk;

    // Combinational sine-generator phase path.
    assign fpn = phase + inc;

    note_phase_controller #(
        .CLK_HZ    (16),
        .SAMPLE_HZ (1)
    ) dut (
        .clk_in              (clk),
        .rst_in              (rst_n),
        .cmd_valid_in        (cmd_valid),
        .cmd_on_in           (cmd_on),
        .note_in             (note),
        .octave_in           (octave),
        .full_phase_next_in  (fpn),
        .sample_step_out     (step),
        .phase_out           (phase),
        .phase_increment_out (inc),
        .playing_out         (playing),
        .cmd_error_out       (err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Octave-4 note frequencies (Hz), four decimals.
    real NOTE_HZ [12] = '{261.6256, 277.1826, 293.6648, 311.1270, 329.6276, 349.2282,
                          369.9944, 391.9954, 415.3047, 440.0000, 466.1638, 493.8833};

    function automatic logic [31:0] expect_inc(input int nt, input int oc);
        logic [31:0] b;
        b = 32'($rtoi(NOTE_HZ[nt] * 4294967296.0 / 8000.0 + 0.5));
        if (oc >= 4) return b << (oc - 4);
        return b >> (4 - oc);
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        active;
        logic        rel;
        logic        pv;
        logic        pon;
        logic        err;
        logic [31:0] phase;
        logic [31:0] inc;
        logic [31:0] pinc;
        logic [7:0]  cnt;
    } model_t;

    model_t m;

    function automatic model_t model_next(input model_t s, input logic rn, input logic cv,
                                          input logic con, input logic [3:0] nt,
                                          input logic [2:0] oc);
        model_t      r;
        logic [31:0] nxt;
        logic        bad;
        r = s;
        if (!rn) begin
            r = '0;
            return r;
        end
        bad   = cv && con && (nt >= 4'd12);
        r.err = bad;
        nxt   = s.phase + s.inc;
        if (int'(s.cnt) == N - 1) begin
            r.cnt = 8'd0;
            r.pv  = 1'b0;
            if (!s.active) begin
                if (s.pv && s.pon) begin
                    r.active = 1'b1;
                    r.inc    = s.pinc;
                end
            end else if (!s.rel) begin
                r.phase = nxt;
                if (s.pv && s.pon) begin
                    r.inc = s.pinc;
                end else if (s.pv) begin
`ifdef ZERO_CROSS_RELEASE_EN
                    r.rel = 1'b1;
`else
                    r.active = 1'b0;
                    r.phase  = 32'd0;
                    r.inc    = 32'd0;
`endif
                end
            end else begin
                r.phase = nxt;
                if (s.pv && s.pon) begin
                    r.rel = 1'b0;
                    r.inc = s.pinc;
                end else if (nxt < s.phase) begin
                    r.active = 1'b0;
                    r.rel    = 1'b0;
                    r.phase  = 32'd0;
                    r.inc    = 32'd0;
                end
            end
        end else begin
            r.cnt = 8'(s.cnt + 8'd1);
        end
        if (cv && !bad) begin
            r.pv   = 1'b1;
            r.pon  = con;
            r.pinc = con ? expect_inc(int'(nt), int'(oc)) : 32'd0;
        end
        return r;
    endfunction

    always @(posedge clk) m <= model_next(m, rst_n, cmd_valid, cmd_on, note, octave);

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic on, input logic [3:0] nt, input logic [2:0] oc);
        $display("cmd on=%0d note=%0d octave=%0d at t=%0t", on, nt, oc, $time);
        cmd_valid = 1'b1;
        cmd_on    = on;
        note      = nt;
        octave    = oc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Advance to the cycle right after the next strobe (per the model's count).
    task automatic to_after_strobe();
        while (int'(m.cnt) != N - 1) @(negedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic exp_step;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        n_vec++; if (phase !== 32'd0) begin n_err++; $display("FAIL reset_phase: got %0d expected 0", phase); end
        n_vec++; if (inc !== 32'd0) begin n_err++; $display("FAIL reset_inc: got %0d expected 0", inc); end
        n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL reset_playing: got %0b expected 0", playing); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %0b expected 0", err); end
        rst_n = 1'b1;
        for (int k = 0; k < int'(N); k++) begin
            exp_step = (k == int'(N) - 1);
            n_vec++;
            if (step !== exp_step) begin
                n_err++;
                $display("FAIL reset_strobe_cycle%0d: got %0b expected %0b", k, step, exp_step);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_a4();
        send(1'b1, 4'd9, 3'd4);
        to_after_strobe();
        n_vec++; if (inc !== 32'd236223201) begin n_err++; $display("FAIL a4_inc: got %0d expected 236223201", inc); end
        n_vec++; if (playing !== 1'b1) begin n_err++; $display("FAIL a4_playing: got %0b expected 1", playing); end
        n_vec++; if (phase !== 32'd0) begin n_err++; $display("FAIL a4_phase0: got %0d expected 0", phase); end
        repeat (3) to_after_strobe();
        n_vec++; if (phase !== 32'd708669603) begin n_err++; $display("FAIL a4_phase3: got %0d expected 708669603", phase); end
    endtask

    task automatic test_octave();
        send(1'b1, 4'd0, 3'd5);
        to_after_strobe();
        n_vec++; if (inc !== 32'd280918348) begin n_err++; $display("FAIL c5_inc: got %0d expected 280918348", inc); end
        n_vec++; if (phase !== 32'd944892804) begin n_err++; $display("FAIL c5_phase: got %0d expected 944892804", phase); end
        send(1'b1, 4'd0, 3'd2);
        to_after_strobe();
        n_vec++; if (inc !== 32'd35114793) begin n_err++; $display("FAIL c2_inc: got %0d expected 35114793", inc); end
        n_vec++; if (phase !== 32'd1225811152) begin n_err++; $display("FAIL c2_phase: got %0d expected 1225811152", phase); end
    endtask

    task automatic test_release();
        send(1'b1, 4'd9, 3'd4);
        to_after_strobe();
        // Note-off carries junk note/octave fields; it must not be rejected.
        send(1'b0, 4'd15, 3'd7);
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL off_no_err: got %0b expected 0", err); end
        to_after_strobe();
`ifdef ZERO_CROSS_RELEASE_EN
        n_vec++; if (phase !== 32'd1497149146) begin n_err++; $display("FAIL rel_phase: got %0d expected 1497149146", phase); end
        // Phase reaches 4095604357 after 11 more strobes; the 12th wraps.
        for (int s = 0; s < 11; s++) begin
            n_vec++; if (playing !== 1'b1) begin n_err++; $display("FAIL rel_hold%0d: got %0b expected 1", s, playing); end
            to_after_strobe();
        end
        n_vec++; if (playing !== 1'b1) begin n_err++; $display("FAIL rel_hold_last: got %0b expected 1", playing); end
        to_after_strobe();
`endif
        n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL stop_playing: got %0b expected 0", playing); end
        n_vec++; if (phase !== 32'd0) begin n_err++; $display("FAIL stop_phase: got %0d expected 0", phase); end
        n_vec++; if (inc !== 32'd0) begin n_err++; $display("FAIL stop_inc: got %0d expected 0", inc); end
    endtask

    task automatic test_reject();
        send(1'b1, 4'd9, 3'd4);
        to_after_strobe();
        send(1'b1, 4'd13, 3'd4);
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL rej_pulse: got %0b expected 1", err); end
        @(negedge clk);
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rej_pulse_end: got %0b expected 0", err); end
        to_after_strobe();
        n_vec++; if (inc !== 32'd236223201) begin n_err++; $display("FAIL rej_inc: got %0d expected 236223201", inc); end
        n_vec++; if (playing !== 1'b1) begin n_err++; $display("FAIL rej_playing: got %0b expected 1", playing); end
    endtask

    task automatic test_same_cycle();
        while (int'(m.cnt) != N - 1) @(negedge clk);
        send(1'b1, 4'd7, 3'd3);
        n_vec++; if (inc !== 32'd236223201) begin n_err++; $display("FAIL same_early: got %0d expected 236223201", inc); end
        to_after_strobe();
        n_vec++; if (inc !== 32'd105225464) begin n_err++; $display("FAIL same_applied: got %0d expected 105225464", inc); end
    endtask

    task automatic test_back_to_back();
        send(1'b1, 4'd4, 3'd4);
        send(1'b1, 4'd6, 3'd5);
        to_after_strobe();
        n_vec++; if (inc !== 32'd397278462) begin n_err++; $display("FAIL overwrite_inc: got %0d expected 397278462", inc); end
    endtask

    task automatic test_reset_mid();
`ifdef ZERO_CROSS_RELEASE_EN
        send(1'b0, 4'd0, 3'd0);
        to_after_strobe();
`endif
        send(1'b1, 4'd11, 3'd6);
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL rstmid_playing: got %0b expected 0", playing); end
        n_vec++; if (phase !== 32'd0) begin n_err++; $display("FAIL rstmid_phase: got %0d expected 0", phase); end
        n_vec++; if (inc !== 32'd0) begin n_err++; $display("FAIL rstmid_inc: got %0d expected 0", inc); end
        n_vec++; if (step !== 1'b0) begin n_err++; $display("FAIL rstmid_step: got %0b expected 0", step); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * N + 2) @(negedge clk);
        n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL rstmid_discard_playing: got %0b expected 0", playing); end
        n_vec++; if (inc !== 32'd0) begin n_err++; $display("FAIL rstmid_discard_inc: got %0d expected 0", inc); end
    endtask

    task automatic test_random();
        int rate;
        for (int c = 0; c < 4000; c++) begin
            n_vec++;
            if (step !== (int'(m.cnt) == N - 1)) begin
                n_err++; $display("FAIL rnd_step c%0d: got %0b expected %0b", c, step, int'(m.cnt) == N - 1);
            end
            n_vec++; if (phase !== m.phase) begin n_err++; $display("FAIL rnd_phase c%0d: got %0d expected %0d", c, phase, m.phase); end
            n_vec++; if (inc !== m.inc) begin n_err++; $display("FAIL rnd_inc c%0d: got %0d expected %0d", c, inc, m.inc); end
            n_vec++; if (playing !== m.active) begin n_err++; $display("FAIL rnd_playing c%0d: got %0b expected %0b", c, playing, m.active); end
            n_vec++; if (err !== m.err) begin n_err++; $display("FAIL rnd_err c%0d: got %0b expected %0b", c, err, m.err); end
            // Alternate busy and quiet stretches so releases get to reach a wrap.
            rate      = ((c / 500) % 2 == 1) ? 200 : 10;
            cmd_valid = ($urandom_range(0, rate - 1) == 0);
            cmd_on    = ($urandom_range(0, 3) != 0);
            note      = 4'($urandom_range(0, 15));
            octave    = 3'($urandom_range(0, 7));
            rst_n     = ($urandom_range(0, 799) != 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_on    = 1'b0;
        note      = 4'd0;
        octave    = 3'd0;
        test_reset();
        test_a4();
        test_octave();
        test_release();
        test_reject();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/note_phase_controller.md
# note_phase_controller

Per-voice phase controller that sits directly upstream of the sine generator. It turns note-on/note-off commands into a phase increment, generates the 8 kHz sample strobe, and holds the voice's 32-bit phase register. It drives the sine generator's `phase_offset_in`, `phase_increment` and `valid_info_in`, and closes the loop through its `full_phase_next_out`. Phase stays continuous across note changes, and release ends at a phase wrap so the voice stops without a click.

## Interface

**Parameters**

- `CLK_HZ`, default 100_000_000: system clock frequency.
- `SAMPLE_HZ`, default 8000: sample strobe rate. `CLK_HZ / SAMPLE_HZ` must be an integer ≥ 2.

**Ports**

- `clk_in` — input, 1: single clock.
- `rst_in` — input, 1: reset. Synchronous, active-low.
- `cmd_valid_in` — input, 1: command strobe, 1 cycle.
- `cmd_on_in` — input, 1: 1 = note-on, 0 = note-off.
- `note_in` — input, 4: semitone 0..11 (C..B).
- `octave_in` — input, 3: octave 0..7.
- `full_phase_next_in` — input, 32: from the sine generator's `full_phase_next_out`.
- `sample_step_out` — output, 1: 1-cycle strobe every `CLK_HZ/SAMPLE_HZ` cycles.
- `phase_out` — output, 32: to `phase_offset_in`.
- `phase_increment_out` — output, 32: to `phase_increment`.
- `playing_out` — output, 1: to `valid_info_in`.
- `cmd_error_out` — output, 1: 1-cycle pulse when a command is rejected.

## Operation

**Sample strobe**
- The divider counts 0..N−1, with N = `CLK_HZ/SAMPLE_HZ`.
- `sample_step_out` = 1 on the cycle where count == N−1; the count then wraps to 0.

**Command capture**
- On `cmd_valid_in`, the command goes into a one-entry pending slot.
- A newer command overwrites an unapplied one (last wins).
- A note-on with `note_in` ≥ 12 is dropped and pulses `cmd_error_out` on the next cycle.
- Note-off ignores `note_in`/`octave_in`.

**Increment computation**
- inc = BASE_INC[note] shifted by (octave − 4).
- Left shift for octave > 4; logical right shift for octave < 4.
- BASE_INC holds octave-4 values: round(f·2^32/SAMPLE_HZ). Examples: C4 = 140_459_174, A4 = 236_223_201.

**FSM states: IDLE, PLAY, RELEASE.** All transitions and register updates happen only on strobe cycles.

- **IDLE**
  - Pending note-on → PLAY: increment ← computed inc; phase stays 0.
  - Pending note-off → cleared, no effect.
- **PLAY**
  - Phase ← `full_phase_next_in`.
  - Pending note-on → increment ← new inc, phase continues (no reset).
  - Pending note-off → RELEASE.
- **RELEASE**
  - Phase ← `full_phase_next_in`.
  - If `full_phase_next_in` < `phase_out` (unsigned wrap) → IDLE: phase ← 0, increment ← 0.
  - Pending note-on → PLAY with the new increment, phase continuous.
- **Pending slot:** cleared on the strobe that consumes it.
- **Same-cycle command and strobe:** a `cmd_valid_in` arriving on a strobe cycle is captured and applied at the *next* strobe. The slot's old contents are consumed on this strobe.
- **`playing_out`:** 1 in PLAY and RELEASE, 0 in IDLE.
- **Arithmetic:** all 32-bit unsigned; wrap modulo 2^32 is intended.

## Timing

- **Reset values:** `sample_step_out` 0, `phase_out` 0, `phase_increment_out` 0, `playing_out` 0, `cmd_error_out` 0; divider 0; FSM IDLE; pending slot empty.
- **Strobe timing:** the first strobe is at cycle N−1 after reset deasserts.
- **Command latency:** outputs change on the cycle after the consuming strobe, i.e. 1 to N+1 cycles after `cmd_valid_in`.
- **Phase update:** `phase_out` changes only on the cycle after a strobe. The sine generator is combinational, so `full_phase_next_in` is sampled on the strobe cycle itself.
- **Reset mid-note:** return to reset values on the next edge; the pending command is discarded.

## Configuration

Macro: `ZERO_CROSS_RELEASE_EN`.

- **Defined:** RELEASE behaves as described above; the voice stops at the next phase wrap.
- **Undefined:**
  - The RELEASE state is not built.
  - Note-off in PLAY goes directly to IDLE on the consuming strobe: phase ← 0, increment ← 0.

## Structure

- **Package `note_phase_pkg`:**
  - `BASE_INC[12]` localparam array.
  - `phase_state_t` enum (IDLE/PLAY/RELEASE).
  - `phase_t` (logic [31:0]).
  - Function `oct_shift(inc, octave)`.
- **Sub-module `sample_tick_gen`:** parameterised divider that produces `sample_step_out`. Reusable by the mixer/output stage.
- **FSM, command capture and increment mux:** remain in `note_phase_controller`.

## Test plan

1. **Reset:** drive `rst_in`=0 for 5 cycles, then release → all outputs 0, and the first `sample_step_out` is at cycle N−1. (Shrink N for sim with `CLK_HZ`=16, `SAMPLE_HZ`=1.)
2. **A4 note-on:** note-on A4 (`note_in`=9, `octave_in`=4) → after the next strobe, `phase_increment_out` = 236_223_201 and `playing_out` = 1. After 3 further strobes, `phase_out` = 708_669_603.
3. **Octave shift:** note-on C5 → increment 280_918_348. Then note-on C2 → increment 35_114_793, with `phase_out` continuous (no reset).
4. **Zero-cross release:** with `ZERO_CROSS_RELEASE_EN`, note-off while in PLAY at A4 → `playing_out` stays 1 until the first strobe where the phase wraps, then all outputs become 0. Without the macro → outputs are 0 right after the consuming strobe.
5. **Rejection, same-cycle and overwrite:** note-on with `note_in`=13 → `cmd_error_out` pulses once and state is unchanged. A command on a strobe cycle → applied one strobe later. Two commands before a strobe → only the second takes effect.
6. **Reset mid-note:** assert reset mid-note in RELEASE with a command pending → all reset values next cycle, and the pending command is never applied.
